// File: rtl/scv_pkg.sv
// Shared types and size constants for the ROM-init sink.
// Region codes, cart size codes and the size-code helper.
package scv_pkg;

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    CHR  = 3'd1,
    APU  = 3'd2,
    CART = 3'd3,
    NONE = 3'd4
  } rominit_region_t;

  typedef enum logic [2:0] {
    CSZ_8K   = 3'd0,
    CSZ_16K  = 3'd1,
    CSZ_32K  = 3'd2,
    CSZ_64K  = 3'd3,
    CSZ_128K = 3'd4
  } cart_sz_t;

  localparam int BOOT_AW_DEF = 12;
  localparam int CHR_AW_DEF  = 10;
  localparam int APU_AW_DEF  = 9;
  localparam int CART_AW_DEF = 17;

  localparam logic [24:0] SZ_8K  = 25'd8192;
  localparam logic [24:0] SZ_16K = 25'd16384;
  localparam logic [24:0] SZ_32K = 25'd32768;
  localparam logic [24:0] SZ_64K = 25'd65536;

  function automatic cart_sz_t cart_sz_of(input logic [24:0] len);
    if (len <= SZ_8K)       return CSZ_8K;
    else if (len <= SZ_16K) return CSZ_16K;
    else if (len <= SZ_32K) return CSZ_32K;
    else if (len <= SZ_64K) return CSZ_64K;
    else                    return CSZ_128K;
  endfunction

endpackage

// File: rtl/rominit_apu_pack.sv
// Pairs APU bytes little-endian into 16-bit words.
// An unpaired low byte is written with a zero high byte on flush.
module rominit_apu_pack
  import scv_pkg::*;
#(
  parameter int AW = APU_AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          odd,
  input  logic          flush,
  input  logic [AW-1:0] wa,
  input  logic [7:0]    data,
  output logic          we,
  output logic [AW-1:0] a,
  output logic [15:0]   d
);

  logic [7:0]    lo_q;
  logic [AW-1:0] wa_q;
  logic          pend_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      we     <= 1'b0;
      a      <= '0;
      d      <= '0;
      lo_q   <= '0;
      wa_q   <= '0;
      pend_q <= 1'b0;
    end else begin
      we <= 1'b0;
      if (en && !odd) begin
        lo_q   <= data;
        wa_q   <= wa;
        pend_q <= 1'b1;
      end else if (en) begin
        we     <= 1'b1;
        a      <= wa;
        d      <= {data, lo_q};
        pend_q <= 1'b0;
      end else if (flush && pend_q) begin
        we     <= 1'b1;
        a      <= wa_q;
        d      <= {8'h00, lo_q};
        pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rominit_sink.sv
// ROM-init byte stream sink: routes sessions to boot/chr/apu/cart ROMs.
// Optional per-region checksums with ROMINIT_CHECKSUM_EN.
module rominit_sink
  import scv_pkg::*;
#(
  parameter int BOOT_AW = BOOT_AW_DEF,
  parameter int CHR_AW  = CHR_AW_DEF,
  parameter int APU_AW  = APU_AW_DEF,
  parameter int CART_AW = CART_AW_DEF
) (
  input  logic               CLK,
  input  logic               RES,
  input  logic               ROMINIT_SEL_BOOT,
  input  logic               ROMINIT_SEL_CHR,
  input  logic               ROMINIT_SEL_APU,
  input  logic               ROMINIT_SEL_CART,
  input  logic [24:0]        ROMINIT_ADDR,
  input  logic [7:0]         ROMINIT_DATA,
  input  logic               ROMINIT_VALID,
  output logic               BOOT_WE,
  output logic [BOOT_AW-1:0] BOOT_A,
  output logic [7:0]         BOOT_D,
  output logic               CHR_WE,
  output logic [CHR_AW-1:0]  CHR_A,
  output logic [7:0]         CHR_D,
  output logic               APU_WE,
  output logic [APU_AW-1:0]  APU_A,
  output logic [15:0]        APU_D,
  output logic               CART_WE,
  output logic [CART_AW-1:0] CART_A,
  output logic [7:0]         CART_D,
  output logic [2:0]         CART_SZ,
  output logic [3:0]         LOADED,
  output logic               ERR
`ifdef ROMINIT_CHECKSUM_EN
  ,
  output logic [3:0][15:0]   CKSUM
`endif
);

  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_FLUSH, S_IGNORE
  } state_t;

  state_t          state, nxt;
  rominit_region_t region_q, sel_region, cur_region;
  logic [3:0]      sel, sel_q;
  logic [24:0]     last_q;
  logic            valid_q, rise, start, ign;
  logic            accept, in_range, wr, err_set;

  assign sel = {ROMINIT_SEL_CART, ROMINIT_SEL_APU,
                ROMINIT_SEL_CHR, ROMINIT_SEL_BOOT};

  always_comb begin
    sel_region = NONE;
    if ($onehot(sel)) begin
      unique case (1'b1)
        sel[0]:  sel_region = BOOT;
        sel[1]:  sel_region = CHR;
        sel[2]:  sel_region = APU;
        sel[3]:  sel_region = CART;
        default: sel_region = NONE;
      endcase
    end
  end

  assign rise  = ROMINIT_VALID && !valid_q;
  assign start = (state == S_IDLE) && rise && (sel_region != NONE);
  assign ign   = (state == S_IDLE) && rise && (sel_region == NONE);
  assign cur_region = (state == S_IDLE) ? sel_region : region_q;
  assign accept = ROMINIT_VALID && (start || state == S_LOAD);

  always_comb begin
    in_range = 1'b0;
    case (cur_region)
      BOOT:    in_range = (ROMINIT_ADDR >> BOOT_AW) == '0;
      CHR:     in_range = (ROMINIT_ADDR >> CHR_AW) == '0;
      APU:     in_range = (ROMINIT_ADDR >> (APU_AW + 1)) == '0;
      CART:    in_range = (ROMINIT_ADDR >> CART_AW) == '0;
      default: in_range = 1'b0;
    endcase
  end

  assign wr = accept && in_range;
  assign err_set = ign || (accept && !in_range) ||
                   ((state == S_LOAD || state == S_IGNORE) &&
                    ROMINIT_VALID && (sel != sel_q));

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (start) nxt = S_LOAD;
                else if (ign) nxt = S_IGNORE;
      S_LOAD:   if (!ROMINIT_VALID) nxt = S_FLUSH;
      S_FLUSH:  nxt = S_IDLE;
      S_IGNORE: if (!ROMINIT_VALID) nxt = S_IDLE;
    endcase
  end

  // valid_q resets high so a stream still running across reset is not a new session
  always_ff @(posedge CLK) begin
    if (RES) begin
      state    <= S_IDLE;
      region_q <= NONE;
      valid_q  <= 1'b1;
      sel_q    <= '0;
      last_q   <= '0;
      BOOT_WE  <= 1'b0;
      BOOT_A   <= '0;
      BOOT_D   <= '0;
      CHR_WE   <= 1'b0;
      CHR_A    <= '0;
      CHR_D    <= '0;
      CART_WE  <= 1'b0;
      CART_A   <= '0;
      CART_D   <= '0;
      CART_SZ  <= '0;
      LOADED   <= '0;
      ERR      <= 1'b0;
    end else begin
      state   <= nxt;
      valid_q <= ROMINIT_VALID;
      sel_q   <= sel;
      BOOT_WE <= 1'b0;
      CHR_WE  <= 1'b0;
      CART_WE <= 1'b0;
      if (start) region_q <= sel_region;
      if (accept) last_q <= ROMINIT_ADDR;
      if (err_set) ERR <= 1'b1;
      if (wr && cur_region == BOOT) begin
        BOOT_WE <= 1'b1;
        BOOT_A  <= ROMINIT_ADDR[BOOT_AW-1:0];
        BOOT_D  <= ROMINIT_DATA;
      end
      if (wr && cur_region == CHR) begin
        CHR_WE <= 1'b1;
        CHR_A  <= ROMINIT_ADDR[CHR_AW-1:0];
        CHR_D  <= ROMINIT_DATA;
      end
      if (wr && cur_region == CART) begin
        CART_WE <= 1'b1;
        CART_A  <= ROMINIT_ADDR[CART_AW-1:0];
        CART_D  <= ROMINIT_DATA;
      end
      if (state == S_FLUSH) begin
        LOADED[region_q[1:0]] <= 1'b1;
        if (region_q == CART) CART_SZ <= cart_sz_of(last_q + 25'd1);
      end
    end
  end

  rominit_apu_pack #(.AW(APU_AW)) u_apu_pack (
    .clk   (CLK),
    .rst   (RES),
    .en    (wr && cur_region == APU),
    .odd   (ROMINIT_ADDR[0]),
    .flush (state == S_FLUSH && region_q == APU),
    .wa    (ROMINIT_ADDR[APU_AW:1]),
    .data  (ROMINIT_DATA),
    .we    (APU_WE),
    .a     (APU_A),
    .d     (APU_D)
  );

`ifdef ROMINIT_CHECKSUM_EN
  always_ff @(posedge CLK) begin
    if (RES) begin
      CKSUM <= '0;
    end else if (start) begin
      CKSUM[sel_region[1:0]] <= wr ? 16'(ROMINIT_DATA) : 16'h0;
    end else if (wr) begin
      CKSUM[region_q[1:0]] <= CKSUM[region_q[1:0]] + 16'(ROMINIT_DATA);
    end
  end
`endif

endmodule

// File: tb/tb_rominit_sink.sv
// Directed testbench for rominit_sink.
// Build with ROMINIT_CHECKSUM_EN to also cover checksums.
module tb_rominit_sink;

  logic        CLK, RES;
  logic        SEL_BOOT, SEL_CHR, SEL_APU, SEL_CART;
  logic [24:0] ADDR;
  logic [7:0]  DATA;
  logic        VALID;
  logic        BOOT_WE, CHR_WE, APU_WE, CART_WE;
  logic [11:0] BOOT_A;
  logic [9:0]  CHR_A;
  logic [8:0]  APU_A;
  logic [16:0] CART_A;
  logic [7:0]  BOOT_D, CHR_D, CART_D;
  logic [15:0] APU_D;
  logic [2:0]  CART_SZ;
  logic [3:0]  LOADED;
  logic        ERR;
`ifdef ROMINIT_CHECKSUM_EN
  logic [3:0][15:0] CKSUM;
`endif

  int tests, fails;
  int boot_n, chr_n, cart_n, apu_n;
  int boot_bad, chr_bad, cart_bad;
  logic [8:0]  apu_a_log [8];
  logic [15:0] apu_d_log [8];
  logic        v_q;
  logic [24:0] a_q;
  logic [7:0]  d_q;
  logic [7:0]  apu_bytes [5];

  rominit_sink dut (
    .CLK              (CLK),
    .RES              (RES),
    .ROMINIT_SEL_BOOT (SEL_BOOT),
    .ROMINIT_SEL_CHR  (SEL_CHR),
    .ROMINIT_SEL_APU  (SEL_APU),
    .ROMINIT_SEL_CART (SEL_CART),
    .ROMINIT_ADDR     (ADDR),
    .ROMINIT_DATA     (DATA),
    .ROMINIT_VALID    (VALID),
    .BOOT_WE          (BOOT_WE),
    .BOOT_A           (BOOT_A),
    .BOOT_D           (BOOT_D),
    .CHR_WE           (CHR_WE),
    .CHR_A            (CHR_A),
    .CHR_D            (CHR_D),
    .APU_WE           (APU_WE),
    .APU_A            (APU_A),
    .APU_D            (APU_D),
    .CART_WE          (CART_WE),
    .CART_A           (CART_A),
    .CART_D           (CART_D),
    .CART_SZ          (CART_SZ),
    .LOADED           (LOADED),
    .ERR              (ERR)
`ifdef ROMINIT_CHECKSUM_EN
    ,
    .CKSUM            (CKSUM)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // capture the strobe of each cycle; a write seen next cycle must match it
  always @(posedge CLK) begin
    v_q <= VALID;
    a_q <= ADDR;
    d_q <= DATA;
  end

  always @(negedge CLK) begin
    if (BOOT_WE) begin
      boot_n++;
      if (!v_q || BOOT_A != a_q[11:0] || BOOT_D != d_q) boot_bad++;
    end
    if (CHR_WE) begin
      chr_n++;
      if (!v_q || CHR_A != a_q[9:0] || CHR_D != d_q) chr_bad++;
    end
    if (CART_WE) begin
      cart_n++;
      if (!v_q || CART_A != a_q[16:0] || CART_D != d_q) cart_bad++;
    end
    if (APU_WE) begin
      if (apu_n < 8) begin
        apu_a_log[apu_n] = APU_A;
        apu_d_log[apu_n] = APU_D;
      end
      apu_n++;
    end
  end

  task automatic clear_counts();
    boot_n = 0; chr_n = 0; cart_n = 0; apu_n = 0;
    boot_bad = 0; chr_bad = 0; cart_bad = 0;
  endtask

  task automatic do_reset();
    RES = 1'b1;
    VALID = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RES = 1'b0;
  endtask

  task automatic session(input logic [3:0] sel, input int len, input int mode);
    {SEL_CART, SEL_APU, SEL_CHR, SEL_BOOT} = sel;
    for (int n = 0; n < len; n++) begin
      @(posedge CLK);
      #1;
      VALID = 1'b1;
      ADDR  = 25'(n);
      DATA  = (mode == 1) ? 8'h01 : (mode == 2) ? apu_bytes[n % 5] : 8'(n);
    end
    @(posedge CLK);
    #1;
    VALID = 1'b0;
    ADDR  = '0;
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({BOOT_WE, CHR_WE, APU_WE, CART_WE} !== 4'b0) begin
      fails++;
      $display("FAIL reset_we: got %b want 0000", {BOOT_WE, CHR_WE, APU_WE, CART_WE});
    end
    tests++;
    if (LOADED !== 4'b0 || ERR !== 1'b0 || CART_SZ !== 3'd0) begin
      fails++;
      $display("FAIL reset_flags: loaded %b err %b sz %0d want 0 0 0", LOADED, ERR, CART_SZ);
    end
    tests++;
    if (BOOT_A !== 12'd0 || APU_D !== 16'd0 || CART_A !== 17'd0) begin
      fails++;
      $display("FAIL reset_ad: boot_a %h apu_d %h cart_a %h want 0", BOOT_A, APU_D, CART_A);
    end
  endtask

  task automatic test_boot();
    clear_counts();
    session(4'b0001, 4096, 0);
    tests++;
    if (boot_n != 4096) begin
      fails++;
      $display("FAIL boot_count: got %0d want 4096", boot_n);
    end
    tests++;
    if (boot_bad != 0) begin
      fails++;
      $display("FAIL boot_data: %0d bad writes want 0", boot_bad);
    end
    tests++;
    if (LOADED !== 4'b0001 || ERR !== 1'b0) begin
      fails++;
      $display("FAIL boot_done: loaded %b err %b want 0001 0", LOADED, ERR);
    end
  endtask

  task automatic test_one_byte();
    clear_counts();
    session(4'b0001, 1, 0);
    tests++;
    if (boot_n != 1 || boot_bad != 0) begin
      fails++;
      $display("FAIL one_byte: count %0d bad %0d want 1 0", boot_n, boot_bad);
    end
    tests++;
    if (LOADED !== 4'b0001 || ERR !== 1'b0) begin
      fails++;
      $display("FAIL one_byte_done: loaded %b err %b want 0001 0", LOADED, ERR);
    end
  endtask

  task automatic test_apu();
    clear_counts();
    apu_bytes[0] = 8'h11; apu_bytes[1] = 8'h22; apu_bytes[2] = 8'h33;
    apu_bytes[3] = 8'h44; apu_bytes[4] = 8'h55;
    session(4'b0100, 5, 2);
    tests++;
    if (apu_n != 3) begin
      fails++;
      $display("FAIL apu_count: got %0d want 3", apu_n);
    end
    tests++;
    if (apu_d_log[0] !== 16'h2211 || apu_a_log[0] !== 9'd0) begin
      fails++;
      $display("FAIL apu_w0: got %h@%0d want 2211@0", apu_d_log[0], apu_a_log[0]);
    end
    tests++;
    if (apu_d_log[1] !== 16'h4433 || apu_a_log[1] !== 9'd1) begin
      fails++;
      $display("FAIL apu_w1: got %h@%0d want 4433@1", apu_d_log[1], apu_a_log[1]);
    end
    tests++;
    if (apu_d_log[2] !== 16'h0055 || apu_a_log[2] !== 9'd2) begin
      fails++;
      $display("FAIL apu_flush: got %h@%0d want 0055@2", apu_d_log[2], apu_a_log[2]);
    end
    tests++;
    if (LOADED !== 4'b0101 || ERR !== 1'b0) begin
      fails++;
      $display("FAIL apu_done: loaded %b err %b want 0101 0", LOADED, ERR);
    end
  endtask

  task automatic test_cart();
    clear_counts();
    session(4'b1000, 20000, 0);
    tests++;
    if (cart_n != 20000 || cart_bad != 0) begin
      fails++;
      $display("FAIL cart_count: count %0d bad %0d want 20000 0", cart_n, cart_bad);
    end
    tests++;
    if (CART_SZ !== 3'd2 || LOADED !== 4'b1101) begin
      fails++;
      $display("FAIL cart_sz_20000: sz %0d loaded %b want 2 1101", CART_SZ, LOADED);
    end
    clear_counts();
    session(4'b1000, 8192, 0);
    tests++;
    if (cart_n != 8192 || cart_bad != 0) begin
      fails++;
      $display("FAIL cart_reload_count: count %0d bad %0d want 8192 0", cart_n, cart_bad);
    end
    tests++;
    if (CART_SZ !== 3'd0 || LOADED !== 4'b1101 || ERR !== 1'b0) begin
      fails++;
      $display("FAIL cart_sz_8192: sz %0d loaded %b err %b want 0 1101 0", CART_SZ, LOADED, ERR);
    end
  endtask

  task automatic test_chr_overflow();
    clear_counts();
    session(4'b0010, 1025, 0);
    tests++;
    if (chr_n != 1024 || chr_bad != 0) begin
      fails++;
      $display("FAIL chr_overflow_count: count %0d bad %0d want 1024 0", chr_n, chr_bad);
    end
    tests++;
    if (ERR !== 1'b1 || LOADED !== 4'b1111) begin
      fails++;
      $display("FAIL chr_overflow_err: err %b loaded %b want 1 1111", ERR, LOADED);
    end
    clear_counts();
    session(4'b1001, 10, 0);
    tests++;
    if (boot_n + chr_n + cart_n + apu_n != 0) begin
      fails++;
      $display("FAIL multi_sel_writes: got %0d want 0", boot_n + chr_n + cart_n + apu_n);
    end
    tests++;
    if (LOADED !== 4'b1111 || ERR !== 1'b1) begin
      fails++;
      $display("FAIL multi_sel_flags: loaded %b err %b want 1111 1", LOADED, ERR);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    clear_counts();
    {SEL_CART, SEL_APU, SEL_CHR, SEL_BOOT} = 4'b1000;
    for (int n = 0; n < 100; n++) begin
      @(posedge CLK);
      #1;
      VALID = 1'b1;
      ADDR  = 25'(n);
      DATA  = 8'(n);
    end
    @(posedge CLK);
    #1;
    RES  = 1'b1;
    ADDR = 25'd100;
    DATA = 8'd100;
    @(posedge CLK);
    #1;
    tests++;
    if (CART_WE !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_we: got %b want 0", CART_WE);
    end
    RES = 1'b0;
    for (int n = 101; n < 111; n++) begin
      @(posedge CLK);
      #1;
      ADDR = 25'(n);
      DATA = 8'(n);
    end
    @(posedge CLK);
    #1;
    VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    tests++;
    if (cart_n != 100 || cart_bad != 0) begin
      fails++;
      $display("FAIL reset_mid_count: count %0d bad %0d want 100 0", cart_n, cart_bad);
    end
    tests++;
    if (LOADED !== 4'b0000 || ERR !== 1'b0 || CART_SZ !== 3'd0) begin
      fails++;
      $display("FAIL reset_mid_flags: loaded %b err %b sz %0d want 0 0 0", LOADED, ERR, CART_SZ);
    end
  endtask

  task automatic test_sel_change();
    clear_counts();
    {SEL_CART, SEL_APU, SEL_CHR, SEL_BOOT} = 4'b0001;
    for (int n = 0; n < 4; n++) begin
      @(posedge CLK);
      #1;
      VALID = 1'b1;
      ADDR  = 25'(n);
      DATA  = 8'(n + 7);
      if (n == 2) SEL_CHR = 1'b1;
    end
    @(posedge CLK);
    #1;
    VALID = 1'b0;
    {SEL_CART, SEL_APU, SEL_CHR, SEL_BOOT} = 4'b0000;
    repeat (3) @(posedge CLK);
    #1;
    tests++;
    if (boot_n != 4 || boot_bad != 0 || chr_n != 0) begin
      fails++;
      $display("FAIL sel_change_writes: boot %0d bad %0d chr %0d want 4 0 0", boot_n, boot_bad, chr_n);
    end
    tests++;
    if (ERR !== 1'b1 || LOADED !== 4'b0001) begin
      fails++;
      $display("FAIL sel_change_flags: err %b loaded %b want 1 0001", ERR, LOADED);
    end
  endtask

`ifdef ROMINIT_CHECKSUM_EN
  task automatic test_cksum();
    clear_counts();
    session(4'b0010, 256, 1);
    tests++;
    if (chr_n != 256 || CKSUM[1] !== 16'h0100) begin
      fails++;
      $display("FAIL cksum_chr: count %0d sum %h want 256 0100", chr_n, CKSUM[1]);
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    RES = 1'b1;
    VALID = 1'b0;
    ADDR = '0;
    DATA = '0;
    {SEL_CART, SEL_APU, SEL_CHR, SEL_BOOT} = 4'b0000;
    clear_counts();
    test_reset();
    test_boot();
    test_one_byte();
    test_apu();
    test_cart();
    test_chr_overflow();
    test_reset_mid();
    test_sel_change();
`ifdef ROMINIT_CHECKSUM_EN
    test_cksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
